// File: rtl/frame_packer.sv
// Packs an sop/eop framed byte stream into one DATAPACK_BIT-wide packet and pushes it to the queue FIFO.
// Optional build macro: PACKER_ZERO_CHECK_EN (drop frames that contain an in-frame 0x00 byte).
module frame_packer #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DATAPACK_BIT = 1024,
   parameter int unsigned PRIORITY_BIT = 3,
   parameter int unsigned DATA_NUMBIT  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_valid,
   input  logic                    i_sop,
   input  logic                    i_eop,
   input  logic [DATA_WIDTH-1:0]   i_data,
   output logic                    i_ready,
   input  logic                    fifo_full,
   output logic                    pack_wr_en,
   output logic [DATAPACK_BIT-1:0] pack_data,
   output logic [DATA_NUMBIT-1:0]  pack_len,
   output logic [PRIORITY_BIT-1:0] pack_prior,
   output logic                    err_ovf,
   output logic                    err_frame
);

   localparam int unsigned MAX_BYTES = DATAPACK_BIT / DATA_WIDTH;
   localparam int unsigned IDX_W     = DATA_NUMBIT;
   localparam int unsigned BIT_W     = $clog2(DATAPACK_BIT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_PUSH    = 2'd2,
      S_DROP    = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [DATAPACK_BIT-1:0] buf_q, buf_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    wr_en_q, wr_en_d;
   logic [DATAPACK_BIT-1:0] data_q, data_d;
   logic [DATA_NUMBIT-1:0]  len_q, len_d;
   logic [PRIORITY_BIT-1:0] prior_q, prior_d;
   logic                    ovf_q, ovf_d;
   logic                    frm_q, frm_d;

   logic accept;
   logic zero_byte;
   logic do_start;
   logic do_push;

   // Places byte d at slot idx, first byte at the MSB end.
   function automatic logic [DATAPACK_BIT-1:0] put_byte(
      input logic [DATAPACK_BIT-1:0] b,
      input logic [IDX_W-1:0]        idx,
      input logic [DATA_WIDTH-1:0]   d
   );
      logic [DATAPACK_BIT-1:0] r;
      logic [BIT_W-1:0]        base;
      r    = b;
      base = BIT_W'((MAX_BYTES - 1 - 32'(idx)) * DATA_WIDTH);
      r[base +: DATA_WIDTH] = d;
      return r;
   endfunction

   assign i_ready = (state_q != S_PUSH);
   assign accept  = i_valid && i_ready;

   always_comb begin
`ifdef PACKER_ZERO_CHECK_EN
      zero_byte = (i_data == '0);
`else
      zero_byte = 1'b0;
`endif
   end

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      idx_d    = idx_q;
      wr_en_d  = 1'b0;
      data_d   = data_q;
      len_d    = len_q;
      prior_d  = prior_q;
      ovf_d    = 1'b0;
      frm_d    = 1'b0;
      do_start = 1'b0;
      do_push  = 1'b0;

      case (state_q)
         S_IDLE, S_DROP: begin
            if (accept) begin
               if (i_sop) begin
                  do_start = 1'b1;
               end else if (state_q == S_DROP && i_eop) begin
                  buf_d   = '0;
                  idx_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         S_COLLECT: begin
            if (accept) begin
               if (i_sop) begin
                  frm_d    = 1'b1;
                  do_start = 1'b1;
               end else if (idx_q == IDX_W'(MAX_BYTES)) begin
                  ovf_d   = 1'b1;
                  buf_d   = '0;
                  idx_d   = '0;
                  state_d = i_eop ? S_IDLE : S_DROP;
               end else if (zero_byte) begin
                  frm_d   = 1'b1;
                  buf_d   = '0;
                  idx_d   = '0;
                  state_d = i_eop ? S_IDLE : S_DROP;
               end else begin
                  buf_d   = put_byte(buf_q, idx_q, i_data);
                  idx_d   = idx_q + IDX_W'(1);
                  do_push = i_eop;
               end
            end
         end
         S_PUSH: begin
            // Stay one cycle past the write strobe, then clear and reopen.
            if (wr_en_q) begin
               buf_d   = '0;
               idx_d   = '0;
               state_d = S_IDLE;
            end else if (!fifo_full) begin
               wr_en_d = 1'b1;
               data_d  = buf_q;
               len_d   = DATA_NUMBIT'(idx_q);
               prior_d = buf_q[DATAPACK_BIT-DATA_WIDTH +: PRIORITY_BIT];
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_start) begin
         if (zero_byte) begin
            frm_d   = 1'b1;
            buf_d   = '0;
            idx_d   = '0;
            state_d = i_eop ? S_IDLE : S_DROP;
         end else begin
            buf_d   = put_byte('0, IDX_W'(0), i_data);
            idx_d   = IDX_W'(1);
            state_d = S_COLLECT;
            do_push = i_eop;
         end
      end

      // Fast path: write on the eop edge when the FIFO has room, else wait in PUSH.
      if (do_push) begin
         state_d = S_PUSH;
         if (!fifo_full) begin
            wr_en_d = 1'b1;
            data_d  = buf_d;
            len_d   = DATA_NUMBIT'(idx_d);
            prior_d = buf_d[DATAPACK_BIT-DATA_WIDTH +: PRIORITY_BIT];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
         wr_en_q <= 1'b0;
         data_q  <= '0;
         len_q   <= '0;
         prior_q <= '0;
         ovf_q   <= 1'b0;
         frm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         wr_en_q <= wr_en_d;
         data_q  <= data_d;
         len_q   <= len_d;
         prior_q <= prior_d;
         ovf_q   <= ovf_d;
         frm_q   <= frm_d;
      end
   end

   assign pack_wr_en = wr_en_q;
   assign pack_data  = data_q;
   assign pack_len   = len_q;
   assign pack_prior = prior_q;
   assign err_ovf    = ovf_q;
   assign err_frame  = frm_q;

endmodule
